// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the sequencing controller and the pipeline.
//  master : the controller (pipe_ctrl) - samples stall requests and EX branch
//           resolution, drives stall/flush/redirect controls and the stall counter.
//  slave  : the pipeline side - drives requests and branch info, consumes controls.
// Signals:
//  if/id/ex/mem_stall_req  per-stage stall requests
//  branch_taken_i          taken branch/jump resolved in EX
//  branch_target_i         redirect target (ADDR_W)
//  stall_o                 hold bits [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//  flush_o                 clear IF/ID and ID/EX to NOP on next edge
//  pc_redirect_o           PC loads redirect_pc_o on next edge
//  redirect_pc_o           redirect target (ADDR_W)
//  stall_cnt_o             saturating count of PC-stall cycles (CNT_W)
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              if_stall_req;
  logic              id_stall_req;
  logic              ex_stall_req;
  logic              mem_stall_req;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic              pc_redirect_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
    input  branch_taken_i, branch_target_i,
    output stall_o, flush_o, pc_redirect_o, redirect_pc_o, stall_cnt_o
  );

  modport slave (
    output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
    output branch_taken_i, branch_target_i,
    input  stall_o, flush_o, pc_redirect_o, redirect_pc_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
//  - Merges per-stage stall requests into one stall vector (deepest requester wins).
//  - Accepts EX-resolved branch/jump redirects and flushes IF/ID and ID/EX.
//  - If IF is busy when a redirect is accepted, parks the target until the
//    pipeline is quiet, then redirects (flushing the stale fetch).
//  - Counts PC-stall cycles, saturating.
// Ports:
//  clk  clock, rising edge
//  rst  synchronous active-high reset; all outputs forced to 0 while asserted
//  bus  pipe_ctrl_if.master - requests/branch in, stall/flush/redirect/count out
module pipe_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.master bus
);

  localparam logic StRun    = 1'b0;
  localparam logic StWaitIf = 1'b1;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [5:0]        req_vec;
  logic [5:0]        stall;
  logic              flush;
  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic              accept;
  logic              all_clear;

  // Deepest requester wins: a stalled stage also holds everything upstream.
  always_comb begin
    req_vec = 6'b000000;
    if (bus.mem_stall_req)     req_vec = 6'b011111;
    else if (bus.ex_stall_req) req_vec = 6'b001111;
    else if (bus.id_stall_req) req_vec = 6'b000111;
    else if (bus.if_stall_req) req_vec = 6'b000011;
  end

  // A branch seen while EX/MEM is held is ignored; EX re-presents it later.
  assign accept    = bus.branch_taken_i & ~bus.ex_stall_req & ~bus.mem_stall_req;
  assign all_clear = ~(bus.if_stall_req | bus.id_stall_req |
                       bus.ex_stall_req | bus.mem_stall_req);

  always_comb begin
    stall    = req_vec;
    flush    = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    state_d  = state_q;
    pend_d   = pend_q;
    case (state_q)
      StRun: begin
        if (accept) begin
          flush = 1'b1;
          if (!bus.if_stall_req) begin
            // EX/MEM/IF are free and the ID hazard is on the wrong path.
            stall    = 6'b000000;
            redir    = 1'b1;
            redir_pc = bus.branch_target_i;
          end else begin
            stall   = 6'b000011;
            pend_d  = bus.branch_target_i;
            state_d = StWaitIf;
          end
        end
      end
      StWaitIf: begin
        if (all_clear) begin
          // Flush again so the stale in-flight fetch never reaches ID.
          stall    = 6'b000000;
          flush    = 1'b1;
          redir    = 1'b1;
          redir_pc = pend_q;
          state_d  = StRun;
        end else begin
          stall = req_vec | 6'b000111;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall[0] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_o       = rst ? 6'b000000 : stall;
  assign bus.flush_o       = rst ? 1'b0 : flush;
  assign bus.pc_redirect_o = rst ? 1'b0 : redir;
  assign bus.redirect_pc_o = rst ? '0 : redir_pc;
  assign bus.stall_cnt_o   = rst ? '0 : cnt_q;

endmodule
